// File: rtl/march_ctrl.sv
// March C- sequencer: drives an external up/down address counter, issues memory
// read/write strobes with all-zeros/all-ones backgrounds and checks read data.
// Element list: E0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 dn(r0,w1), E4 dn(r1,w0),
// E5 up(r0).
module march_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_q,
  input  logic              addr_cout,
  output logic              cnt_ld,
  output logic              cnt_u_d,
  output logic              cnt_cen,
  output logic [ADDR_W-1:0] cnt_d_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  typedef enum logic [2:0] {StIdle, StLoad, StOp, StStep, StEval, StDone} state_e;

  localparam logic [2:0] ElemLast = 3'd5;

  state_e            state_q;
  logic [2:0]        elem_q;
  logic              op_q;
  logic              pend_q;
  logic              pend_exp_q;
  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;

  logic elem_down;
  logic op_read;
  logic op_last;
  logic rd_val;
  logic wr_val;

  // Element/op decode: every read is op 0, E0 and E5 have a single op.
  always_comb begin
    elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    op_read   = !op_q && (elem_q != 3'd0);
    op_last   = (elem_q == 3'd0 || elem_q == ElemLast) ? 1'b1 : op_q;
    rd_val    = (elem_q == 3'd2) || (elem_q == 3'd4);
    wr_val    = (elem_q == 3'd1) || (elem_q == 3'd3);
  end

  // Sequencer state, pending compare and sticky first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      elem_q      <= 3'd0;
      op_q        <= 1'b0;
      pend_q      <= 1'b0;
      pend_exp_q  <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else begin
      // Read data returns one cycle after the strobe; the counter has not moved yet.
      if (pend_q && !fail_q && (mem_rdata != {DATA_W{pend_exp_q}})) begin
        fail_q      <= 1'b1;
        fail_addr_q <= addr_q;
        fail_elem_q <= elem_q;
      end
      pend_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StLoad;
            elem_q      <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
          end
        end
        StLoad: begin
          state_q <= StOp;
          op_q    <= 1'b0;
        end
        StOp: begin
          if (op_read) begin
            pend_q     <= 1'b1;
            pend_exp_q <= rd_val;
          end
          if (op_last) begin
            state_q <= StStep;
          end else begin
            op_q <= 1'b1;
          end
        end
        StStep: state_q <= StEval;
        StEval: begin
          op_q <= 1'b0;
          if (addr_cout) begin
            if (elem_q == ElemLast) begin
              state_q <= StDone;
              elem_q  <= 3'd0;
            end else begin
              state_q <= StLoad;
              elem_q  <= elem_q + 3'd1;
            end
          end else begin
            state_q <= StOp;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore output decode from registered state, element and op index.
  always_comb begin
    cnt_ld    = 1'b0;
    cnt_cen   = 1'b0;
    cnt_u_d   = 1'b1;
    cnt_d_in  = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StLoad: begin
        busy     = 1'b1;
        cnt_ld   = 1'b1;
        cnt_cen  = 1'b1;
        cnt_u_d  = !elem_down;
        cnt_d_in = {ADDR_W{elem_down}};
      end
      StOp: begin
        busy   = 1'b1;
        mem_cs = 1'b1;
        if (!op_read) begin
          mem_we    = 1'b1;
          mem_wdata = {DATA_W{wr_val}};
        end
      end
      StStep: begin
        busy    = 1'b1;
        cnt_cen = 1'b1;
        cnt_u_d = !elem_down;
      end
      StEval:  busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_march_ctrl.sv
// Bench for march_ctrl with a 2-bit address counter model and a 4-word RAM that can
// carry one stuck-at bit fault.
module tb_march_ctrl;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int          RunCycles = 6 + 22 * 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_cout;
  logic              cnt_ld;
  logic              cnt_u_d;
  logic              cnt_cen;
  logic [ADDR_W-1:0] cnt_d_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;

  march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .addr_q    (addr_q),
    .addr_cout (addr_cout),
    .cnt_ld    (cnt_ld),
    .cnt_u_d   (cnt_u_d),
    .cnt_cen   (cnt_cen),
    .cnt_d_in  (cnt_d_in),
    .mem_addr  (mem_addr),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address counter: load clears cout, a step sets cout when it wraps.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      addr_cout <= 1'b0;
    end else if (cnt_cen) begin
      if (cnt_ld) begin
        addr_q    <= cnt_d_in;
        addr_cout <= 1'b0;
      end else if (cnt_u_d) begin
        addr_cout <= (addr_q == 2'd3);
        addr_q    <= addr_q + 2'd1;
      end else begin
        addr_cout <= (addr_q == 2'd0);
        addr_q    <= addr_q - 2'd1;
      end
    end
  end

  // RAM with one optional stuck-at bit applied on write.
  logic [DATA_W-1:0] ram [4];
  logic              flt_en;
  logic [1:0]        flt_addr;
  logic [2:0]        flt_bit;
  logic              flt_val;

  function automatic logic [DATA_W-1:0] faulty(input logic [1:0] a, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] m;
    m = 8'h01 << flt_bit;
    if (flt_en && a == flt_addr) return flt_val ? (d | m) : (d & ~m);
    return d;
  endfunction

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= faulty(mem_addr, mem_wdata);
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       flt_en;
    logic [1:0] flt_addr;
    logic [2:0] flt_bit;
    logic       flt_val;
    logic       poke;
    logic       exp_fail;
    logic [1:0] exp_addr;
    logic [2:0] exp_elem;
  } vec_t;

  vec_t vecs [5];

  int         cyc;
  int         nwr;
  int         nrd;
  int         nld;
  int         e3_n;
  logic [1:0] e3_addr [4];

  // One run from IDLE; optionally pulses start again while busy.
  task automatic run_one(input logic poke);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; nwr = 0; nrd = 0; nld = 0; e3_n = 0;
    while (busy && cyc < 400) begin
      cyc++;
      if (mem_cs) begin
        if (mem_we) nwr++;
        else        nrd++;
      end
      if (cnt_ld) begin
        nld++;
        if (nld == 4) begin
          check("e3_load_cen", {31'd0, cnt_cen}, 32'd1);
          check("e3_load_u_d", {31'd0, cnt_u_d}, 32'd0);
          check("e3_load_d_in", {30'd0, cnt_d_in}, 32'd3);
        end
      end
      if (nld == 4 && mem_cs && !mem_we && e3_n < 4) begin
        e3_addr[e3_n] = mem_addr;
        e3_n++;
      end
      start = poke && (cyc == 30);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_cycles", cyc, RunCycles);
    check("done_pulse", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("done_clear", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] exp_ram;
    int                n;
    int                ld;
    checks = 0; failures = 0;
    start = 1'b0; flt_en = 1'b0; flt_addr = 2'd0; flt_bit = 3'd0; flt_val = 1'b0;

    vecs[0] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
    vecs[1] = '{1'b1, 2'd2, 3'd3, 1'b0, 1'b0, 1'b1, 2'd2, 3'd2};
    vecs[2] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0};
    vecs[3] = '{1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2};
    vecs[4] = '{1'b1, 2'd1, 3'd5, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1};

    rst_n = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fail", {31'd0, fail}, 32'd0);
    check("rst_u_d", {31'd0, cnt_u_d}, 32'd1);
    check("rst_cs_ld_cen", {29'd0, mem_cs, cnt_ld, cnt_cen}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      flt_en = vecs[i].flt_en; flt_addr = vecs[i].flt_addr;
      flt_bit = vecs[i].flt_bit; flt_val = vecs[i].flt_val;
      run_one(vecs[i].poke);
      check($sformatf("v%0d_fail", i), {31'd0, fail}, {31'd0, vecs[i].exp_fail});
      check($sformatf("v%0d_fail_addr", i), {30'd0, fail_addr}, {30'd0, vecs[i].exp_addr});
      check($sformatf("v%0d_fail_elem", i), {29'd0, fail_elem}, {29'd0, vecs[i].exp_elem});
      check($sformatf("v%0d_writes", i), nwr, 32'd20);
      check($sformatf("v%0d_reads", i), nrd, 32'd20);
      check($sformatf("v%0d_e3_reads", i), e3_n, 32'd4);
      for (int a = 0; a < 4; a++) begin
        check($sformatf("v%0d_e3_addr%0d", i, a), {30'd0, e3_addr[a]}, 3 - a);
        exp_ram = (vecs[i].flt_en && vecs[i].flt_val && vecs[i].flt_addr == a)
                  ? (8'h01 << vecs[i].flt_bit) : 8'h00;
        check($sformatf("v%0d_ram%0d", i, a), {24'd0, ram[a]}, {24'd0, exp_ram});
      end
    end

    // Reset in the middle of E1 after a stuck-at-1 has already been flagged.
    flt_en = 1'b1; flt_addr = 2'd1; flt_bit = 3'd5; flt_val = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; ld = 0;
    while (ld < 2 && n < 200) begin
      if (cnt_ld) ld++;
      n++;
      @(posedge clk); #1;
    end
    check("reach_e1", ld, 32'd2);
    repeat (9) @(posedge clk);
    #1;
    check("mid_fail_set", {31'd0, fail}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_fail", {31'd0, fail}, 32'd0);
    check("arst_fail_addr", {30'd0, fail_addr}, 32'd0);
    check("arst_strobes", {28'd0, mem_cs, mem_we, cnt_ld, cnt_cen}, 32'd0);
    check("arst_u_d_d_in", {29'd0, cnt_u_d, cnt_d_in}, 32'd4);
    check("arst_wdata", {24'd0, mem_wdata}, 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    flt_en = 1'b0;
    run_one(1'b0);
    check("post_rst_fail", {31'd0, fail}, 32'd0);
    check("post_rst_writes", nwr, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/march_ctrl.md
# march_ctrl

March C- sequencer that drives the MBIST address counter and the memory under test. It issues counter load/step/direction controls, consumes the counter's address and carry-out, generates memory read/write strobes and background data, and compares read data. It reports pass/fail, the first failing address, and the first failing March element.

## Interface
- ADDR_W, 10: address width; equals the counter `length`.
- DATA_W, 8: memory data width.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- addr_q  in  ADDR_W  counter output `q`.
- addr_cout  in  1  counter carry-out `cout`.
- cnt_ld  out  1  counter load enable.
- cnt_u_d  out  1  counter direction: 1 = up, 0 = down.
- cnt_cen  out  1  counter count enable.
- cnt_d_in  out  ADDR_W  counter load value.
- mem_addr  out  ADDR_W  memory address; combinational pass-through of addr_q.
- mem_cs  out  1  memory access strobe.
- mem_we  out  1  1 = write, 0 = read; valid only when mem_cs = 1.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid the cycle after a read strobe.
- busy  out  1  high from the cycle after start is accepted until the final check.
- done  out  1  one-cycle pulse at the end of a run.
- fail  out  1  sticky mismatch flag; cleared when start is accepted.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_elem  out  3  element index (0-5) of the first mismatch.

## Operation
- Elements:
  - E0 up (w0)
  - E1 up (r0,w1)
  - E2 up (r1,w0)
  - E3 down (r0,w1)
  - E4 down (r1,w0)
  - E5 up (r0)
- Data: 0 = all zeros, 1 = all ones of width DATA_W.
- FSM states: IDLE, LOAD, OP, STEP, EVAL, DONE. Outputs are Moore-decoded from registered state, op index and element index.
- IDLE → LOAD on start. Start is ignored in every other state.
- LOAD:
  - cnt_cen=1, cnt_ld=1.
  - cnt_d_in = 0 for up elements, all-ones for down elements.
  - cnt_u_d = element direction.
  - Next state: OP with op index 0.
- OP:
  - mem_cs=1; mem_we and mem_wdata per the current op.
  - If more ops remain in the element, stay in OP with op index+1; otherwise go to STEP.
- STEP:
  - cnt_cen=1, cnt_ld=0, cnt_u_d = direction.
  - Next state: EVAL.
- EVAL:
  - No strobes are issued.
  - If addr_cout=1, the element is complete: go to LOAD of the next element, or to DONE after E5.
  - Otherwise go to OP.
- DONE: done=1 for one cycle, then IDLE.
- Compare:
  - A read in cycle k sets a pending flag with the expected value.
  - In cycle k+1 (next OP or STEP), mem_rdata is compared against the expected value.
  - addr_q is still unchanged in that cycle, because the counter steps at the end of STEP.
- On the first mismatch of a run, set fail, capture fail_addr=addr_q and fail_elem. Later mismatches leave all three unchanged. The run always completes and never aborts.
- Idle/reset values:
  - cnt_ld=0, cnt_cen=0, cnt_u_d=1, cnt_d_in=0.
  - mem_cs=0, mem_we=0, mem_wdata=0.
  - busy=0, done=0, fail=0, fail_addr=0, fail_elem=0.
  - Element index 0, pending-compare flag 0.

## Timing
- N = 2^ADDR_W.
- Per address, element cycles = op count + 2 (STEP and EVAL).
- busy is high for exactly 6 + 22·N cycles: 6 LOAD cycles plus 22 cycles per address.
- done is asserted in the cycle after busy falls.
- Accepting start clears fail, fail_addr and fail_elem in the cycle busy rises.
- addr_cout is sampled only in EVAL, where it reflects the preceding STEP. The counter clears cout on load, so a stale cout never ends an element.
- Wrap: up elements end when the step from all-ones wraps to 0; down elements end when the step from 0 wraps to all-ones.
- Reset asserted mid-run:
  - All outputs return to reset values immediately (asynchronously).
  - Any pending compare is discarded.
  - After rst_n deasserts, the block waits in IDLE for a new start.

## Test plan
With ADDR_W=2, DATA_W=8, a `counter` of length 2, and a behavioural 1-cycle-latency RAM:
- Fault-free run, start pulse:
  - busy high for 94 cycles, then done=1 for one cycle.
  - fail=0.
  - Exactly 20 writes and 20 reads.
  - Final RAM content 0x00 at all 4 addresses.
- Bit 3 stuck-at-0 at address 2 → fail=1, fail_addr=2, fail_elem=2 (E2 reads 0xF7, expects 0xFF). Run still completes in 94 cycles.
- E3 LOAD cycle → cnt_ld=1, cnt_cen=1, cnt_u_d=0, cnt_d_in=3. First E3 read is at mem_addr=3; address sequence is 3, 2, 1, 0.
- start pulsed while busy → ignored, with no change to cycle count. A second run after a failing run clears fail and passes on fault-free RAM.
- rst_n pulsed low during E1 → outputs immediately at reset values, busy=0. A new start runs a full 94-cycle pass.
